ex1_gate: RTL and testbench

- Registered 4-input boolean evaluator with output e = F(a,b,c,d).
- F is held in a 16-entry truth table. The table resets to a parameter default and can be reloaded at runtime through a config port.
- Sits as a small leaf logic cell. Inputs are synchronous to clk; e is a registered, glitch-free output.
- Default function is e = (a AND b) OR (c AND d).

---
 rtl/ex1_pkg.sv | 9 +
 rtl/ex1_lut16.sv | 19 +
 rtl/ex1_gate.sv | 53 +++++
 tb/tb_ex1_gate.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ex1_pkg.sv
// Shared constants for the ex1 4-input boolean evaluator.
//   EX1_DEFAULT_TABLE : reset truth table, e = (a & b) | (c & d)
//   EX1_IDX_W         : width of the {a,b,c,d} table index
package ex1_pkg;

  localparam logic [15:0] EX1_DEFAULT_TABLE = 16'hF888;
  localparam int unsigned EX1_IDX_W = 4;

endpackage

// File: rtl/ex1_lut16.sv
// Purely combinational 16:1 bit select out of a truth table.
//   lut_table [15:0] : truth table, bit i is the result for index i
//   idx       [3:0]  : table index, {a,b,c,d}
//   sel_bit          : lut_table[idx]
// The names "table" and "bit" are SystemVerilog keywords. The ports are
// therefore called lut_table and sel_bit.
module ex1_lut16
  import ex1_pkg::*;
(
  input  logic [15:0]          lut_table,
  input  logic [EX1_IDX_W-1:0] idx,
  output logic                 sel_bit
);

  always_comb begin
    sel_bit = lut_table[idx];
  end

endmodule

// File: rtl/ex1_gate.sv
// Registered 4-input boolean evaluator with a runtime-reloadable truth table.
//   clk        : single clock, rising edge
//   rst_n      : synchronous reset, active-low
//   a,b,c,d    : function inputs, index bits 3..0
//   cfg_we     : truth-table write enable (ignored during reset)
//   cfg_table  : new truth table, captured when cfg_we=1
//   table_q    : current truth table, for readback
//   e          : registered result, table_q[{a,b,c,d}] one cycle later
module ex1_gate
  import ex1_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = EX1_DEFAULT_TABLE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        cfg_we,
  input  logic [15:0] cfg_table,
  output logic [15:0] table_q,
  output logic        e
);

  logic [EX1_IDX_W-1:0] idx;
  logic                 lut_bit;

  always_comb begin
    idx = {a, b, c, d};
  end

  ex1_lut16 u_lut (
    .lut_table (table_q),
    .idx       (idx),
    .sel_bit   (lut_bit)
  );

  // The lookup reads the registered table_q. A write on the same edge is
  // therefore seen by the evaluation only on the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e       <= 1'b0;
      table_q <= TRUTH_TABLE;
    end else begin
      e <= lut_bit;
      if (cfg_we) begin
        table_q <= cfg_table;
      end
    end
  end

endmodule

// File: tb/tb_ex1_gate.sv
module tb_ex1_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a, b, c, d;
  logic        cfg_we;
  logic [15:0] cfg_table;
  logic [15:0] table_q;
  logic        e;

  int n_cmp = 0;
  int n_bad = 0;

  ex1_gate #(.TRUTH_TABLE(16'hF888)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .cfg_we    (cfg_we),
    .cfg_table (cfg_table),
    .table_q   (table_q),
    .e         (e)
  );

  always #5 clk = ~clk;

  // Behavioural model: the table is a plain value, e is the table bit
  // chosen by the 4-bit number abcd, computed before any write lands.
  logic [15:0] m_table;
  logic        m_e;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    int unsigned n;
    n = {28'd0, a, b, c, d};
    if (!rst_n) begin
      m_e     = 1'b0;
      m_table = 16'hF888;
    end else begin
      m_e = 1'(m_table >> n);
      if (cfg_we) m_table = cfg_table;
    end
    m_valid = 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_e", {15'd0, e}, {15'd0, m_e});
      check("model_table", table_q, m_table);
    end
  end

  // Apply inputs, let one rising edge pass, return shortly after it.
  task automatic drive(input logic [3:0] abcd, input logic rn, input logic we,
                       input logic [15:0] tbl);
    {a, b, c, d} = abcd;
    rst_n        = rn;
    cfg_we       = we;
    cfg_table    = tbl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] dflt;
    logic [3:0]  sweep_in  [4];
    logic        sweep_exp [4];
    dflt = 16'hF888;
    sweep_in  = '{4'b0000, 4'b0001, 4'b1111, 4'b1101};
    sweep_exp = '{1'b0, 1'b0, 1'b1, 1'b1};

    {a, b, c, d} = 4'b1111;
    rst_n = 1'b0;
    cfg_we = 1'b0;
    cfg_table = '0;

    // Reset held two cycles with inputs at 1111; cfg_we ignored.
    drive(4'b1111, 1'b0, 1'b1, 16'h0000);
    check("rst1_e", {15'd0, e}, 16'd0);
    check("rst1_table", table_q, 16'hF888);
    drive(4'b1111, 1'b0, 1'b0, 16'h0000);
    check("rst2_e", {15'd0, e}, 16'd0);
    check("rst2_table", table_q, 16'hF888);
    drive(4'b1111, 1'b1, 1'b0, 16'h0000);
    check("release_e", {15'd0, e}, 16'd1);

    // Short default-function sweep.
    for (int i = 0; i < 4; i++) begin
      drive(sweep_in[i], 1'b1, 1'b0, 16'h0000);
      check($sformatf("sweep_%b", sweep_in[i]), {15'd0, e}, {15'd0, sweep_exp[i]});
    end

    // Exhaustive sweep over the default table.
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b1, 1'b0, 16'h0000);
      check($sformatf("dflt_%0d", i), {15'd0, e}, {15'd0, dflt[i]});
    end

    // Reprogram to NOR4 while inputs are 0000.
    drive(4'b0000, 1'b1, 1'b1, 16'h0001);
    check("wr_edge_old_e", {15'd0, e}, 16'd0);
    check("wr_table", table_q, 16'h0001);
    drive(4'b0000, 1'b1, 1'b0, 16'h0000);
    check("nor4_0000", {15'd0, e}, 16'd1);
    drive(4'b0001, 1'b1, 1'b0, 16'h0000);
    check("nor4_0001", {15'd0, e}, 16'd0);
    check("nor4_table", table_q, 16'h0001);

    // Reset wins over a simultaneous write.
    drive(4'b1111, 1'b1, 1'b1, 16'h8000);
    check("load8000_table", table_q, 16'h8000);
    drive(4'b1111, 1'b1, 1'b0, 16'h0000);
    check("and4_1111", {15'd0, e}, 16'd1);
    drive(4'b1111, 1'b0, 1'b1, 16'h1234);
    check("rst_wins_table", table_q, 16'hF888);
    check("rst_wins_e", {15'd0, e}, 16'd0);

    // Inputs constant across a write of all-ones.
    drive(4'b0000, 1'b1, 1'b0, 16'h0000);
    check("hold_pre", {15'd0, e}, 16'd0);
    drive(4'b0000, 1'b1, 1'b1, 16'hFFFF);
    check("hold_wr_edge", {15'd0, e}, 16'd0);
    drive(4'b0000, 1'b1, 1'b0, 16'h0000);
    check("hold_after", {15'd0, e}, 16'd1);
    check("hold_table", table_q, 16'hFFFF);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
